// File: rtl/wb_axi4lite_bridge_pkg.sv
// Shared types for the Wishbone-to-AXI4-Lite master bridge: FSM state encoding
// and the AXI response codes.
package wb_axi4lite_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } bridge_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // AXI4-Lite has no exclusive access, so anything but OKAY is a bus error.
    function automatic logic resp_is_ok(input logic [1:0] resp);
        return (resp == OKAY) && (resp != EXOKAY) && (resp != SLVERR) && (resp != DECERR);
    endfunction

endpackage

// File: rtl/wb_axi4lite_master_bridge.sv
// Wishbone classic slave to AXI4-Lite master bridge: one transaction at a time,
// every output driven straight from a register.
module wb_axi4lite_master_bridge
    import wb_axi4lite_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,

    output logic [ADDR_WIDTH-1:0]   aw_addr,
    output logic                    aw_valid,
    input  logic                    aw_ready,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    w_valid,
    input  logic                    w_ready,
    input  logic [1:0]              b_resp,
    input  logic                    b_valid,
    output logic                    b_ready,
    output logic [ADDR_WIDTH-1:0]   ar_addr,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    input  logic [DATA_WIDTH-1:0]   r_data,
    input  logic [1:0]              r_resp,
    input  logic                    r_valid,
    output logic                    r_ready
);

    bridge_state_e state_reg;
    logic          cyc_lost_reg;
    logic          aw_done;
    logic          w_done;
    logic          cyc_ok;

    // A channel counts as finished once its valid has dropped or is handshaking now.
    assign aw_done = !aw_valid || aw_ready;
    assign w_done  = !w_valid  || w_ready;
    assign cyc_ok  = wb_cyc_i && !cyc_lost_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            cyc_lost_reg <= 1'b0;
            wb_dat_o     <= '0;
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            aw_addr      <= '0;
            aw_valid     <= 1'b0;
            w_data       <= '0;
            w_strb       <= '0;
            w_valid      <= 1'b0;
            b_ready      <= 1'b0;
            ar_addr      <= '0;
            ar_valid     <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            // Once the master abandons the cycle, the AXI side still finishes
            // but the Wishbone side must not see a termination.
            if (state_reg != IDLE && state_reg != DONE && !wb_cyc_i) begin
                cyc_lost_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        cyc_lost_reg <= 1'b0;
                        if (wb_we_i) begin
                            aw_addr   <= wb_adr_i;
                            w_data    <= wb_dat_i;
                            w_strb    <= wb_sel_i;
                            aw_valid  <= 1'b1;
                            w_valid   <= 1'b1;
                            state_reg <= WR_REQ;
                        end else begin
                            ar_addr   <= wb_adr_i;
                            ar_valid  <= 1'b1;
                            state_reg <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (aw_valid && aw_ready) begin
                        aw_valid <= 1'b0;
                    end
                    if (w_valid && w_ready) begin
                        w_valid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        b_ready   <= 1'b1;
                        state_reg <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (b_valid) begin
                        b_ready   <= 1'b0;
                        wb_ack_o  <= cyc_ok && resp_is_ok(b_resp);
                        wb_err_o  <= cyc_ok && !resp_is_ok(b_resp);
                        state_reg <= DONE;
                    end
                end

                RD_REQ: begin
                    if (ar_ready) begin
                        ar_valid  <= 1'b0;
                        r_ready   <= 1'b1;
                        state_reg <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (r_valid) begin
                        r_ready   <= 1'b0;
                        wb_dat_o  <= r_data;
                        wb_ack_o  <= cyc_ok && resp_is_ok(r_resp);
                        wb_err_o  <= cyc_ok && !resp_is_ok(r_resp);
                        state_reg <= DONE;
                    end
                end

                DONE: begin
                    wb_ack_o  <= 1'b0;
                    wb_err_o  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_axi4lite_master_bridge.md
WB_AXI4LITE_MASTER_BRIDGE -- requirements
Module: wb_axi4lite_master_bridge

Interface
REQ-001 The block SHALL expose parameter ADDR_WIDTH, default 32, AXI/Wishbone byte address width.
REQ-002 The block SHALL expose parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 clk_i  in  1  single clock for both interfaces.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 Wishbone classic slave ports SHALL be:
- wb_adr_i in ADDR_WIDTH
- wb_dat_i in 32
- wb_sel_i in 4
- wb_we_i in 1
- wb_cyc_i in 1
- wb_stb_i in 1
- wb_dat_o out 32
- wb_ack_o out 1
- wb_err_o out 1
REQ-006 AXI4-Lite master ports SHALL be:
- aw_addr out ADDR_WIDTH, aw_valid out 1, aw_ready in 1
- w_data out 32, w_strb out 4, w_valid out 1, w_ready in 1
- b_resp in 2, b_valid in 1, b_ready out 1
- ar_addr out ADDR_WIDTH, ar_valid out 1, ar_ready in 1
- r_data in 32, r_resp in 2, r_valid in 1, r_ready out 1

Function
REQ-007 The FSM SHALL have states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; all outputs are registered.
REQ-008 In IDLE with wb_cyc_i&wb_stb_i, the block SHALL capture adr/dat/sel/we and enter WR_REQ (we=1) or RD_REQ (we=0).
REQ-009 WR_REQ SHALL assert aw_valid and w_valid the cycle after capture, dropping each independently on its own handshake (valid&ready), and go to WR_RESP once both have completed, in either order or the same cycle.
REQ-010 WR_RESP SHALL assert b_ready and go to DONE on b_valid, latching b_resp.
REQ-011 RD_REQ SHALL assert ar_valid until ar_ready, then go to RD_RESP; RD_RESP SHALL assert r_ready and go to DONE on r_valid, latching r_data and r_resp.
REQ-012 DONE SHALL last exactly one cycle and pulse wb_ack_o if the latched resp==OKAY (2'b00), else wb_err_o, never both; then return to IDLE.
REQ-013 wb_dat_o SHALL hold the latched r_data from DONE until the next read completes; for writes it is don't-care.
REQ-014 aw_addr/ar_addr SHALL equal the captured wb_adr_i; w_strb SHALL equal the captured wb_sel_i; valid signals, once asserted, SHALL stay high with stable payload until handshake.
REQ-015 With all readys and responses returned the same cycle they are requested, latency SHALL be: stb sampled at N, valid at N+1, b_ready/r_ready at N+2, ack at N+3.
REQ-016 If wb_cyc_i drops before DONE, the AXI transaction SHALL still complete, and DONE SHALL produce no ack or err.
REQ-017 Only one transaction SHALL be outstanding; Wishbone inputs are ignored outside IDLE.
REQ-018 A stb still high in the cycle after DONE SHALL be treated as a new transfer.

Reset
REQ-019 On rst_ni low, the block SHALL asynchronously enter IDLE and clear all valid/ready/ack/err outputs, wb_dat_o, addresses, w_data and w_strb to 0.
REQ-020 Reset mid-transaction SHALL abandon it immediately, with no ack or err.

Structure
REQ-021 Package wb_axi4lite_bridge_pkg SHALL hold the FSM state enum and the AXI resp constants OKAY/EXOKAY/SLVERR/DECERR.
REQ-022 The block SHALL be a single module with no sub-modules.

Verification
REQ-023 Write 0x0000_1000 <- 0xDEADBEEF, sel=0xF, all readys high, b_resp=OKAY -> aw/w valid at N+1, w_strb=0xF, one-cycle ack at N+3.
REQ-024 Read 0x0000_2004 with r_data=0x12345678, r_resp=OKAY, r_valid delayed 5 cycles -> ack one cycle after the r handshake, wb_dat_o=0x12345678.
REQ-025 Write with aw_ready delayed 3 cycles and w_ready immediate -> w_valid drops after 1 cycle, aw_valid held 3 cycles, single ack.
REQ-026 Read with r_resp=SLVERR (2'b10) -> wb_err_o pulses one cycle and wb_ack_o stays 0.
REQ-027 wb_cyc_i dropped while in WR_RESP, then b_valid arrives -> b handshake occurs, no ack or err, FSM returns to IDLE.
REQ-028 rst_ni asserted in RD_RESP -> outputs 0 that cycle; a subsequent read completes normally.
